// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: defaults, FSM encoding and the
// {pc,inst} record passed between the fetch datapath and its hold buffer.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc,inst} buffer that parks a fetched word while decode is stalled.
// Clear wins over load so a redirect always empties it.
module fetch_hold_buf
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  fetch_word_t word_i,
  output logic        full_o,
  output fetch_word_t word_o
);

  logic        full_q;
  fetch_word_t word_q;

  // Buffer contents and occupancy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      word_q <= word_i;
    end else begin
      full_q <= full_q;
    end
  end

  assign full_o = full_q;
  assign word_o = word_q;

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch: single-outstanding imem requests, registered output
// to decode with stall hold, redirect handling and stale-response dropping.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_inst_q, if_inst_d;

  logic         hb_load_s, hb_clear_s, hb_full_s;
  fetch_word_t  hb_word_s;
  logic         req_fire_s;

  assign req_fire_s = (state_q == ST_REQ) && imem_req_ready;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hb_load_s),
    .clear_i (hb_clear_s),
    .word_i  ('{pc: pc_q, inst: imem_rsp_data}),
    .full_o  (hb_full_s),
    .word_o  (hb_word_s)
  );

  // Next-state logic for FSM, PC, drop flag and decode output register
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    hb_load_s  = 1'b0;
    hb_clear_s = 1'b0;

    if (redirect_valid) begin
      pc_d       = align_word(redirect_pc);
      if_valid_d = 1'b0;
      if_inst_d  = NOP_INST;
      hb_clear_s = 1'b1;
      // A response still owed by memory must be swallowed before the refetch is issued
      if (((state_q == ST_WAIT) && !imem_rsp_valid) || req_fire_s) begin
        drop_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = ST_REQ;
      end
    end else begin
      if (!if_stall) begin
        if_valid_d = 1'b0;
        if_inst_d  = NOP_INST;
      end else begin
        if_valid_d = if_valid_q;
      end

      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) state_d = ST_WAIT;
          else                state_d = ST_REQ;
        end
        ST_WAIT: begin
          if (!imem_rsp_valid) begin
            state_d = ST_WAIT;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            pc_d = pc_q + PC_STEP;
            if (!if_valid_q || !if_stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_inst_d  = imem_rsp_data;
              state_d    = ST_REQ;
            end else begin
              hb_load_s = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!if_stall) begin
            if_valid_d = hb_full_s;
            if_pc_d    = hb_word_s.pc;
            if_inst_d  = hb_full_s ? hb_word_s.inst : NOP_INST;
            hb_clear_s = 1'b1;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, PC, drop flag and decode output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
  assign misalign_err   = redirect_valid && (redirect_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a cycle table for straight-line fetch, stall and
// redirect-in-WAIT, then hand sequences for redirect corner cases, wrap and reset.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_stall       (if_stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // memory model state
  int          rsp_lat;
  logic        pend;
  int          pend_wait;
  logic [31:0] pend_addr;
  logic [31:0] out_log[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [31:0] ra,
                         input logic iv, input logic [31:0] ip);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, rv});
    chk({tag, ".req_addr"}, imem_req_addr, ra);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, iv});
    chk({tag, ".if_pc"}, if_pc, ip);
    chk({tag, ".if_inst"}, if_inst, iv ? memw(ip) : NOP);
  endtask

  // one clock; returns at the following falling edge with memory inputs updated
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (if_valid && !if_stall) out_log.push_back(if_pc);
    @(posedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_wait = rsp_lat - 1;
    end
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memw(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_wait--;
      end
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    int          lat;
    logic        mis;
    logic        req_v;
    logic [31:0] req_a;
    logic        ifv;
    logic [31:0] ifpc;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // stall rv  rpc        lat mis req  addr        ifv pc
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h4,   1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h4,   1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h8,   1'b1, 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h8,   1'b0, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'hC,   1'b1, 32'h8};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'hC,   1'b1, 32'h8};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h10,  1'b1, 32'h8};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h10,  1'b1, 32'hC};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   2, 1'b0, 1'b0, 32'h10,  1'b0, 32'hC};
    vecs[14] = '{1'b0, 1'b1, 32'h100, 1, 1'b0, 1'b0, 32'h100, 1'b0, 32'hC};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h100, 1'b0, 32'hC};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b0, 32'h100, 1'b0, 32'hC};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b1, 32'h104, 1'b1, 32'h100};

    n_checks = 0;
    n_errors = 0;
    rsp_lat  = 1;
    pend     = 1'b0;
    pend_wait = 0;
    pend_addr = 32'h0;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_stall       = 1'b0;
    #1 rst_n = 1'b0;

    // reset values
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset.misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;

    // straight fetch, stall with hold buffer, redirect while waiting
    for (int i = 0; i < 18; i++) begin
      if_stall       = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      rsp_lat        = vecs[i].lat;
      #1;
      chk($sformatf("row%0d.misalign", i), {31'd0, misalign_err}, {31'd0, vecs[i].mis});
      tick();
      chk_out($sformatf("row%0d", i), vecs[i].req_v, vecs[i].req_a, vecs[i].ifv, vecs[i].ifpc);
    end
    redirect_valid = 1'b0;

    // decode saw each word exactly once, stale word@16 never delivered
    chk("stream.len", out_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk($sformatf("stream%0d", i), out_log[i], 32'(i * 4));

    // redirect in the same cycle as the response
    tick();
    chk("t4.pre.if_valid", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1 chk("t4.misalign", {31'd0, misalign_err}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk_out("t4.redir", 1'b1, 32'h300, 1'b0, 32'h100);
    tick();
    chk("t4.wait.req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk_out("t4.first", 1'b1, 32'h304, 1'b1, 32'h300);

    // misaligned redirect while a request is being accepted
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    #1 chk("t5.misalign.on", {31'd0, misalign_err}, 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1 chk("t5.misalign.off", {31'd0, misalign_err}, 32'd0);
    chk_out("t5.drop", 1'b0, 32'h200, 1'b0, 32'h300);
    tick();
    chk_out("t5.req", 1'b1, 32'h200, 1'b0, 32'h300);
    tick();
    tick();
    chk_out("t5.first", 1'b1, 32'h204, 1'b1, 32'h200);

    // redirect to top of memory while memory not ready, then wrap
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk_out("t6.redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h200);
    tick();
    tick();
    chk_out("t6.wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    if_stall = 1'b1;
    tick();
    chk_out("t6.waiting", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);

    // reset mid-WAIT takes effect immediately
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    pend           = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6.rst.misalign", {31'd0, misalign_err}, 32'd0);
    if_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("t6.restart", 1'b1, 32'h0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
